// File: rtl/imm_pkg.sv
// Shared constants for the RISC-V immediate generator: operand width and
// the immediate-format select encodings.
package imm_pkg;
  localparam int XLEN = 32;

  typedef logic [2:0] imm_sel_t;

  localparam imm_sel_t IMM_I  = 3'd0;
  localparam imm_sel_t IMM_B  = 3'd1;
  localparam imm_sel_t IMM_S  = 3'd2;
  localparam imm_sel_t IMM_U  = 3'd3;
  localparam imm_sel_t IMM_J  = 3'd4;
  localparam imm_sel_t IMM_SH = 3'd5;
endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode from instruction bits [31:7].
// IN[k] is instr[k+7], so instr[31] (the sign bit) is IN[24].
module imm_decode
  import imm_pkg::*;
(
  input  logic [24:0]     IN,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic sign;
  assign sign = IN[24];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_type)
      IMM_I:  imm = {{20{sign}}, IN[24:13]};
      IMM_B:  imm = {{19{sign}}, IN[24], IN[0], IN[23:18], IN[4:1], 1'b0};
      IMM_S:  imm = {{20{sign}}, IN[24:18], IN[4:0]};
      IMM_U:  imm = {IN[24:5], 12'b0};
      IMM_J:  imm = {{11{sign}}, IN[24], IN[12:5], IN[13], IN[23:14], 1'b0};
      IMM_SH: imm = {27'b0, IN[17:13]};
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_32.sv
// Registered RISC-V immediate generator: one-cycle latency, result and
// illegal flag held while in_valid is low.
module imm_32
  import imm_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [24:0]   IN,
  input  logic [2:0]    imm_type,
  output logic [W-1:0]  immediate,
  output logic          out_valid,
  output logic          illegal
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  imm_decode u_decode (
    .IN       (IN),
    .imm_type (imm_type),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      immediate <= '0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Hold the last result when no new instruction is presented.
      if (in_valid) begin
        immediate <= W'(dec_imm);
        illegal   <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_imm_32.sv
// Scoreboard bench for imm_32: expected results queued at drive time,
// popped and compared when the registered output appears.
module tb_imm_32;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [24:0] in_bits;
  logic [2:0]  imm_type;
  logic [31:0] immediate;
  logic        out_valid;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  logic        exp_valid;
  logic [31:0] last_imm;
  logic        last_ill;

  imm_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .IN        (in_bits),
    .imm_type  (imm_type),
    .immediate (immediate),
    .out_valid (out_valid),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference decode written against full-instruction bit positions.
  function automatic logic [32:0] model(input logic [24:0] f, input logic [2:0] t);
    logic [31:0] i;
    i = {f, 7'b0};
    case (t)
      3'd0: return {1'b0, {{20{i[31]}}, i[31:20]}};
      3'd1: return {1'b0, {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}};
      3'd2: return {1'b0, {{20{i[31]}}, i[31:25], i[11:7]}};
      3'd3: return {1'b0, i[31:12], 12'b0};
      3'd4: return {1'b0, {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}};
      3'd5: return {1'b0, 27'b0, i[24:20]};
      default: return {1'b1, 32'b0};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_valid <= 1'b0;
    else        exp_valid <= in_valid;
  end

  // Monitor: away from the active edge, compare or verify hold.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("immediate", immediate, e.imm);
          check("illegal", {31'b0, illegal}, {31'b0, e.ill});
          last_imm = e.imm;
          last_ill = e.ill;
        end
      end else begin
        check("hold_imm", immediate, last_imm);
        check("hold_ill", {31'b0, illegal}, {31'b0, last_ill});
      end
    end
  end

  task automatic send(input logic [24:0] f, input logic [2:0] t, input logic [31:0] exp_imm,
                      input logic exp_ill);
    exp_t e;
    in_valid = 1'b1;
    in_bits  = f;
    imm_type = t;
    e.imm = exp_imm;
    e.ill = exp_ill;
    sb_q.push_back(e);
    $display("send type=%0d IN=0x%07h exp_imm=0x%08h exp_ill=%0d", t, f, exp_imm, exp_ill);
    @(posedge clk); #1;
  endtask

  task automatic send_model(input logic [24:0] f, input logic [2:0] t);
    logic [32:0] m;
    m = model(f, t);
    send(f, t, m[31:0], m[32]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_bits  = 25'h1ABCDEF;
    imm_type = 3'd0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  localparam logic [24:0] ONES = '1;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bits  = '0;
    imm_type = '0;
    last_imm = '0;
    last_ill = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_imm", immediate, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_ill", {31'b0, illegal}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back-to-back
    send(25'b1111111111001001100010011, 3'd0, 32'hFFFFFFFC, 1'b0);
    send(25'b0000001001010100000000000, 3'd1, 32'h00000020, 1'b0);
    send(25'b0000000001111001101000000, 3'd2, 32'h00000000, 1'b0);
    send(25'b0000000000000000000001010, 3'd3, 32'h00000000, 1'b0);
    send(25'b0000001000000000000000000, 3'd4, 32'h00000020, 1'b0);
    send(ONES, 3'd1, 32'hFFFFFFFE, 1'b0);
    send(ONES, 3'd2, 32'hFFFFFFFF, 1'b0);
    send(ONES, 3'd3, 32'hFFFFF000, 1'b0);
    send(ONES, 3'd4, 32'hFFFFFFFE, 1'b0);
    send(ONES, 3'd5, 32'h0000001F, 1'b0);
    send(ONES, 3'd0, 32'hFFFFFFFF, 1'b0);
    send(ONES, 3'd6, 32'h00000000, 1'b1);
    send(25'h0123456, 3'd7, 32'h00000000, 1'b1);
    send(ONES, 3'd4, 32'hFFFFFFFE, 1'b0);
    idle(3);

    // Random traffic with occasional bubbles
    for (int k = 0; k < 40; k++) begin
      send_model(25'($urandom), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    // Asynchronous reset between edges
    send(ONES, 3'd3, 32'hFFFFF000, 1'b0);
    send(ONES, 3'd6, 32'h00000000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_imm", immediate, 32'h0);
    check("arst_valid", {31'b0, out_valid}, 32'h0);
    check("arst_ill", {31'b0, illegal}, 32'h0);
    sb_q.delete();
    last_imm = '0;
    last_ill = 1'b0;
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);
    send(25'b1111111111001001100010011, 3'd0, 32'hFFFFFFFC, 1'b0);
    idle(2);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_32.md
Name: imm_32

Overview:
- RISC-V immediate generator for the decode stage.
- Takes instruction bits [31:7] and an immediate-format select, and produces the sign- or zero-extended 32-bit immediate.
- Output is registered, with one-cycle latency and a valid flag, for use by the ALU/branch operand mux.

Parameters:
- XLEN, 32, output immediate width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies IN/imm_type this cycle.
- IN  input  25  instruction bits [31:7]; IN[k] = instr[k+7].
- imm_type  input  3  immediate format select.
- immediate  output  32  registered immediate.
- out_valid  output  1  immediate valid; this is in_valid delayed one cycle.
- illegal  output  1  registered flag: the captured imm_type was unsupported (6 or 7).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (rst_n); all outputs are registered on clk.
- Reset: while rst_n=0, immediate=0, out_valid=0, illegal=0, independent of clk.
- Decode is combinational, from IN and imm_type:
  - I-type (0): sign-extend IN[24:13].
  - B-type (1): sign-extend {IN[24], IN[0], IN[23:18], IN[4:1], 1'b0}; 13-bit value, bit0 = 0.
  - S-type (2): sign-extend {IN[24:18], IN[4:0]}.
  - U-type (3): {IN[24:5], 12'b0}.
  - J-type (4): sign-extend {IN[24], IN[12:5], IN[13], IN[23:14], 1'b0}; 21-bit value.
  - SH-type (5): zero-extend IN[17:13] (shamt); upper 27 bits are 0.
  - 6, 7: decoded value 0 and illegal asserted.
- Sign extension always replicates IN[24] (instr[31]) for I/B/S/J.
- Timing (rising clk):
  - If in_valid=1: immediate and illegal capture the decoded values; out_valid <= 1.
  - If in_valid=0: immediate and illegal hold their previous values; out_valid <= 0.
  - Latency is exactly 1 cycle. Back-to-back valid inputs give one result per cycle.
- Reset asserted mid-stream clears all outputs immediately. After rst_n deasserts, the first output requires a new in_valid.
- There is no backpressure; the consumer must sample whenever out_valid=1.

Decomposition:
- Package imm_pkg:
  - 3-bit localparams: IMM_I=0, IMM_B=1, IMM_S=2, IMM_U=3, IMM_J=4, IMM_SH=5.
  - XLEN constant.
- One combinational sub-module, imm_decode (IN, imm_type -> imm, illegal). imm_32 wraps it with the output registers.

Test Plan:
- I-type: imm_type=0, IN=25'b1111111111001001100010011 (addi s3,s3,-4), in_valid=1 -> next cycle immediate=0xFFFFFFFC, out_valid=1, illegal=0.
- B-type: imm_type=1, IN=25'b0000001001010100000000000 (beq s0,t0,32) -> immediate=0x00000020.
- S/U/J:
  - imm_type=2, IN=25'b0000000001111001101000000 (sw t2,0(s3)) -> 0x00000000.
  - imm_type=3, IN=25'b0000000000000000000001010 (auipc a0,0) -> 0x00000000.
  - imm_type=4, IN=25'b0000001000000000000000000 (jal x0,+32) -> 0x00000020.
- Sign/edge, IN=all ones:
  - type 1 -> 0xFFFFFFFE.
  - type 2 -> 0xFFFFFFFF.
  - type 3 -> 0xFFFFF000.
  - type 4 -> 0xFFFFFFFE.
  - type 5 -> 0x0000001F.
- Illegal/hold/reset:
  - imm_type=6 with in_valid=1 -> immediate=0, illegal=1.
  - in_valid=0 for 3 cycles -> immediate holds, out_valid=0.
  - Assert rst_n=0 between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
